// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the helper that sizes the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time sizing (returns 0 for values <= 1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // The counter must reach WIDTH after the last bit, so it gets one extra bit.
  function automatic int count_width(input int width);
    return clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout is the borrow into the next
// more significant bit.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a single bit position.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
//
// Handshake: start is sampled only in IDLE; the edge that sees start=1 there
// captures a and b and enters SHIFT. busy is high for the WIDTH cycles spent in
// SHIFT. done is a single-cycle pulse in DONE, during which diff, borrow_out and
// overflow already hold the new result; those three outputs then hold until the
// next completion. start seen in SHIFT or DONE is dropped, never queued.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output state_t           fsm_state
);

  localparam int CNT_W = count_width(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-2:0]   partial_q;   // result bits already produced
  logic               borrow_q;
  logic [CNT_W-1:0]   count_q;
  logic               a_msb_q;
  logic               b_msb_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_out_q;
  logic               overflow_q;

  logic               cell_d;
  logic               cell_bout;
  logic               last_bit;
  logic [WIDTH-1:0]   shifted;

  // Single datapath cell fed by the LSBs of the operand shift registers.
  full_subtractor u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // New bit enters at the MSB end; on the last bit this is the full result.
  assign shifted  = {cell_d, partial_q};
  assign last_bit = (count_q == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result update on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr         <= '0;
      b_sr         <= '0;
      partial_q    <= '0;
      borrow_q     <= 1'b0;
      count_q      <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr      <= a;
            b_sr      <= b;
            partial_q <= '0;
            borrow_q  <= 1'b0;
            count_q   <= '0;
            a_msb_q   <= a[WIDTH-1];
            b_msb_q   <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          partial_q <= shifted[WIDTH-1:1];
          borrow_q  <= cell_bout;
          count_q   <= count_q + CNT_W'(1);
          if (last_bit) begin
            diff_q       <= shifted;
            borrow_out_q <= cell_bout;
            // Signed overflow: operand signs differ and the result sign
            // disagrees with the minuend.
            overflow_q   <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed and random subtractions checked
// against an arithmetic reference model through an expected-result queue.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;
  localparam int EW = W + 2;  // {overflow, borrow, diff}

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;
  state_t       fsm_state;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            checks;
  int            errors;
  int            cycle_cnt;
  int            busy_run;
  logic          prev_done;
  logic [W-1:0]  last_diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle_cnt = 0;
  always @(posedge clk) cycle_cnt = cycle_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model from plain integer arithmetic.
  function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int ux;
    int uy;
    int sx;
    int sy;
    int ud;
    int sd;
    logic [W-1:0] dd;
    logic ovf;
    ux  = int'(x);
    uy  = int'(y);
    sx  = x[W-1] ? ux - (1 << W) : ux;
    sy  = y[W-1] ? uy - (1 << W) : uy;
    ud  = ux - uy;
    sd  = sx - sy;
    dd  = ud[W-1:0];
    ovf = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    return {ovf, (ux < uy), dd};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT able to accept on the next edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    logic [W-1:0] held;
    logic [EW-1:0] e;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    acc_q.push_back(cycle_cnt);
    e = model(x, y);
    exp_q.push_back(e);
    held      = last_diff;
    last_diff = e[W-1:0];
    if (!hold) start = 1'b0;
    for (int i = 0; i < W + 1; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i == 3) check("diff_held_mid_op", diff, held);
      @(negedge clk);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    busy_run  = 0;
    prev_done = 1'b0;
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            k;
    if (!rst_n) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL spurious_done: done=1 with no operation outstanding");
        end else begin
          e = exp_q.pop_front();
          k = acc_q.pop_front();
          check("diff", diff, e[W-1:0]);
          check("borrow_out", borrow_out, e[W]);
          check("overflow", overflow, e[W+1]);
          check("done_latency", cycle_cnt, k + W);
          check("busy_cycles", busy_run, W);
          check("busy_low_in_done", busy, 1'b0);
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run = busy_run + 1;
      end
      if (done && prev_done) begin
        errors = errors + 1;
        $display("FAIL done_pulse_width: done high two cycles in a row");
      end
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] dir_a[7] = '{8'h35, 8'h12, 8'h00, 8'h80, 8'h7F, 8'h00, 8'hFF};
  logic [W-1:0] dir_b[7] = '{8'h12, 8'h35, 8'h01, 8'h01, 8'hFF, 8'h00, 8'hFF};

  initial begin
    checks    = 0;
    errors    = 0;
    last_diff = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, '0);
    check("rst_borrow", borrow_out, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, with an idle cycle between operations.
    for (int i = 0; i < 7; i++) begin
      issue(dir_a[i], dir_b[i], 1'b0);
      @(negedge clk);
    end

    // start held high: back-to-back accepts every W+2 edges.
    for (int i = 0; i < 4; i++) begin
      issue(W'($urandom), W'($urandom), (i != 3));
    end

    // Random operands with random idle gaps.
    for (int i = 0; i < 25; i++) begin
      issue(W'($urandom), W'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of SHIFT: nothing may escape.
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_diff", diff, '0);
    check("midrst_borrow", borrow_out, 1'b0);
    check("midrst_overflow", overflow, 1'b0);
    last_diff = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    repeat (W + 2) begin
      @(negedge clk);
      if (done) begin
        errors = errors + 1;
        $display("FAIL reset_leak: done=1 after reset without a new start");
      end
    end
    issue(8'h10, 8'h01, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
